// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM (1-cycle read latency) between NREQ requesters.
// Grants are combinational with bounded burst lock; read responses are tagged back to their issuer.
module sram_rr_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_wen,
  input  logic [NREQ*$clog2(DEPTH)-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]         req_wdata,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               rvalid,
  output logic [WIDTH-1:0]              rdata,
  output logic [$clog2(DEPTH)-1:0]      sram_addr,
  output logic                          sram_ren,
  output logic                          sram_wen,
  output logic [WIDTH-1:0]              sram_d,
  input  logic [WIDTH-1:0]              sram_q
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   prio;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   burst_cnt;
  logic [NREQ-1:0] rd_pend;

  logic            keep;
  logic            any_gnt;
  logic            found;
  logic [IW-1:0]   start;
  logic [IW-1:0]   winner;
  logic [IW:0]     offs;
  logic [IW:0]     sum;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0] rot;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] v);
    return (v == IW'(NREQ - 1)) ? '0 : v + IW'(1);
  endfunction

  // Arbitration: owner keeps the port while requesting and under the burst limit,
  // otherwise search from owner+1 (in a burst) or prio (idle), so handover has no bubble.
  always_comb begin
    keep    = 1'b0;
    start   = prio;
    found   = 1'b0;
    offs    = '0;
    winner  = '0;
    any_gnt = 1'b0;
    gnt     = '0;
    if (state == BURST) begin
      keep  = req[owner] && (burst_cnt < CW'(MAX_BURST));
      start = inc_idx(owner);
    end
    dbl = {req, req} >> start;
    rot = dbl[NREQ-1:0];
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        offs  = (IW+1)'(k);
      end
    end
    sum = {1'b0, start} + offs;
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    if (keep) begin
      winner  = owner;
      any_gnt = 1'b1;
    end else begin
      winner  = sum[IW-1:0];
      any_gnt = found;
    end
    if (any_gnt && !rst) gnt = NREQ'(1) << winner;
  end

  // SRAM port mux driven by the one-hot grant
  always_comb begin
    sram_addr = '0;
    sram_d    = '0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sram_addr = req_addr[i*AW +: AW];
        sram_d    = req_wdata[i*WIDTH +: WIDTH];
        sram_wen  = req_wen[i];
        sram_ren  = !req_wen[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rd_pend   <= '0;
    end else begin
      rd_pend <= gnt & ~req_wen;
      if (state == BURST && !keep) prio <= inc_idx(owner);
      if (!any_gnt) begin
        state     <= IDLE;
        burst_cnt <= '0;
      end else if (keep) begin
        burst_cnt <= burst_cnt + CW'(1);
      end else begin
        state     <= BURST;
        owner     <= winner;
        burst_cnt <= CW'(1);
      end
    end
  end

  // A read issued just before reset must not surface a response while reset is held
  assign rvalid = rst ? '0 : rd_pend;
  assign rdata  = sram_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_sram_rr_arbiter;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wen;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [WIDTH-1:0]     rdata;
  logic [AW-1:0]        sram_addr;
  logic                 sram_ren;
  logic                 sram_wen;
  logic [WIDTH-1:0]     sram_d;
  logic [WIDTH-1:0]     sram_q;

  logic [WIDTH-1:0] mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_addr(sram_addr), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_d;
    if (sram_ren) sram_q <= mem[sram_addr];
  end

  task automatic set_req(input int idx, input logic wen, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] data);
    req_wen[idx] = wen;
    req_addr[idx*AW +: AW] = addr;
    req_wdata[idx*WIDTH +: WIDTH] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1;
      req = 2'b11;
      set_req(0, 1'b0, 5'd1, 32'h0);
      set_req(1, 1'b0, 5'd2, 32'h0);
      #1;
      n_checks += 4;
      if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
      if (sram_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b expected 0", sram_ren); end
      if (sram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", sram_wen); end
      if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    do_reset();
    prev_g = 2'b00;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      req = 2'b11;
      set_req(0, 1'b0, 5'(k), 32'h0);
      set_req(1, 1'b0, 5'(k + 16), 32'h0);
      #1;
      exp_g = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
      n_checks += 2;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", k, gnt, exp_g); end
      if (rvalid !== prev_g) begin n_fail++; $display("FAIL fair_rvalid[%0d]: got %b expected %b", k, rvalid, prev_g); end
      prev_g = exp_g;
    end
    @(negedge clk);
    req = '0;
    #1;
    n_checks += 2;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL fair_idle_gnt: got %b expected 00", gnt); end
    if (rvalid !== 2'b01) begin n_fail++; $display("FAIL fair_last_rvalid: got %b expected 01", rvalid); end
  endtask

  task automatic test_write_read();
    do_reset();
    @(negedge clk);
    req = 2'b01;
    set_req(0, 1'b1, 5'd5, 32'hDEAD);
    #1;
    n_checks += 4;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b expected 01", gnt); end
    if (sram_wen !== 1'b1 || sram_ren !== 1'b0) begin n_fail++; $display("FAIL wr_en: got wen=%b ren=%b expected wen=1 ren=0", sram_wen, sram_ren); end
    if (sram_addr !== 5'd5) begin n_fail++; $display("FAIL wr_addr: got %0d expected 5", sram_addr); end
    if (sram_d !== 32'hDEAD) begin n_fail++; $display("FAIL wr_data: got %h expected 0000dead", sram_d); end
    @(negedge clk);
    req = 2'b10;
    set_req(1, 1'b0, 5'd5, 32'h0);
    #1;
    n_checks += 3;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL rd_gnt: got %b expected 10", gnt); end
    if (sram_ren !== 1'b1 || sram_addr !== 5'd5) begin n_fail++; $display("FAIL rd_port: got ren=%b addr=%0d expected ren=1 addr=5", sram_ren, sram_addr); end
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 00", rvalid); end
    @(negedge clk);
    req = '0;
    #1;
    n_checks += 2;
    if (rvalid !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 10", rvalid); end
    if (rdata !== 32'hDEAD) begin n_fail++; $display("FAIL rd_data: got %h expected 0000dead", rdata); end
  endtask

  task automatic test_early_release();
    logic [1:0] exp_g [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic [1:0] reqs  [4] = '{2'b11, 2'b11, 2'b10, 2'b10};
    do_reset();
    set_req(0, 1'b0, 5'd3, 32'h0);
    set_req(1, 1'b0, 5'd4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = reqs[k];
      #1;
      n_checks++;
      if (gnt !== exp_g[k]) begin n_fail++; $display("FAIL early_gnt[%0d]: got %b expected %b", k, gnt, exp_g[k]); end
    end
    n_checks++;
    if (rvalid !== 2'b10) begin n_fail++; $display("FAIL early_rvalid: got %b expected 10", rvalid); end
  endtask

  task automatic test_mutex();
    int bad = 0;
    logic [1:0] exp_rv;
    do_reset();
    exp_rv = 2'b00;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      req = 2'($urandom_range(0, 3));
      req_wen = 2'($urandom_range(0, 3));
      set_req(0, req_wen[0], 5'($urandom_range(0, 31)), $urandom);
      set_req(1, req_wen[1], 5'($urandom_range(0, 31)), $urandom);
      #1;
      if (sram_ren && sram_wen) bad++;
      if (!$onehot0(gnt) || !$onehot0(rvalid)) bad++;
      if ((gnt & ~req) != 2'b00) bad++;
      if (req != 2'b00 && gnt == 2'b00) bad++;
      if (rvalid !== exp_rv) bad++;
      exp_rv = gnt & ~req_wen;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL mutex: got %0d violations expected 0", bad); end
    req = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_req(0, 1'b0, 5'd7, 32'h0);
    set_req(1, 1'b0, 5'd8, 32'h0);
    @(negedge clk);
    req = 2'b11;
    #1;
    n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL mid_pre_gnt: got %b expected 01", gnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks += 2;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL mid_rst_gnt: got %b expected 00", gnt); end
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rvalid: got %b expected 00", rvalid); end
    @(negedge clk);
    req = 2'b10;
    #1;
    n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL mid_rst_req1: got %b expected 00", gnt); end
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    #1;
    n_checks += 2;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL mid_post_prio: got %b expected 01", gnt); end
    if (rvalid !== 2'b00) begin n_fail++; $display("FAIL mid_post_rvalid: got %b expected 00", rvalid); end
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_wen = '0;
    req_addr = '0;
    req_wdata = '0;
    test_reset();
    test_fairness();
    test_write_read();
    test_early_release();
    test_mutex();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
